// File: rtl/timer_share_arbiter_pkg.sv
// Shared types and defaults for the timer_share_arbiter slice.
// Optional cancel-on-drop behaviour is enabled with TIMER_ARB_CANCEL_EN.
package timer_arb_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} tarb_state_t;
  localparam int TARB_NREQ  = 4;
  localparam int TARB_WIDTH = 4;
endpackage

// File: rtl/timer_share_arbiter_if.sv
// Requester-side bundle of the shared timer: requests and load values in,
// grant/busy/count/done back out.
interface timer_arb_if
  import timer_arb_pkg::*;
#(
  parameter int NREQ  = TARB_NREQ,
  parameter int WIDTH = TARB_WIDTH
);
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0][WIDTH-1:0] load_val;
  logic [NREQ-1:0]            grant;
  logic                       busy;
  logic [WIDTH-1:0]           count;
  logic [NREQ-1:0]            done;

  modport master (output req, load_val, input grant, busy, count, done);
  modport slave  (input req, load_val, output grant, busy, count, done);
endinterface

// File: rtl/timer_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1.
module rr_pick
  import timer_arb_pkg::*;
#(
  parameter int NREQ = TARB_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win,
  output logic            vld
);
  // Walk the search order backwards so the nearest candidate is written last.
  always_comb begin
    win = '0;
    vld = |req;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) win = IW'((int'(ptr) + k) % NREQ);
    end
  end
endmodule

// File: rtl/timer_share_arbiter.sv
// Round-robin owner of a single shared down-counter timer.
// Build option TIMER_ARB_CANCEL_EN: owner dropping req mid-count aborts the interval.
module timer_share_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ  = TARB_NREQ,
  parameter int WIDTH = TARB_WIDTH
) (
  input logic        clk,
  input logic        reset,
  timer_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  tarb_state_t      state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, win;
  logic             win_vld;
  logic [NREQ-1:0]  grant_q, grant_nxt, done_q, done_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             busy_q;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .win (win),
    .vld (win_vld)
  );

`ifdef TIMER_ARB_CANCEL_EN
  logic own_req;
  assign own_req = |(bus.req & grant_q);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_q;
    done_nxt  = '0;
    count_nxt = count_q;
    case (state)
      IDLE: if (win_vld) begin
        state_nxt = COUNT;
        grant_nxt = NREQ'(1) << win;
        count_nxt = bus.load_val[win];
        ptr_nxt   = win;
      end
      COUNT: begin
        if (count_q != '0) count_nxt = count_q - WIDTH'(1);
        else begin
          state_nxt = DONE;
          done_nxt  = grant_q;
        end
`ifdef TIMER_ARB_CANCEL_EN
        // Abort wins even on the zero cycle: no done pulse, count frozen.
        if (!own_req) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          done_nxt  = '0;
          count_nxt = count_q;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= IW'(NREQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr     <= ptr_nxt;
      grant_q <= grant_nxt;
      done_q  <= done_nxt;
      count_q <= count_nxt;
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;
endmodule
